// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sitting on the CPU data-memory port.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_i,
    input  logic [31:0] addr_i,
    input  logic        memwr_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rd_data_o,
    output logic        tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic [15:0]     div_q;
    logic            ovf_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic [1:0] reg_sel;
    logic       we, push_req, push_ok, pop, full, empty;
    logic       unused_ok;

    assign reg_sel   = addr_i[3:2];
    assign we        = sel_i & memwr_i;
    assign push_req  = we && (reg_sel == 2'd0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign pop       = (state_q == S_IDLE) && !empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still fits.
    assign push_ok   = push_req && (!full || pop);
    assign unused_ok = ^{addr_i[31:4], addr_i[1:0], wr_data_i[31:16]};

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wr_data_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= DEFAULT_DIV;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop)     rptr_q <= rptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && !push_ok)
                ovf_q <= 1'b1;
            else if (we && reg_sel == 2'd1 && wr_data_i[3])
                ovf_q <= 1'b0;
            if (we && reg_sel == 2'd2)
                div_q <= (wr_data_i[15:0] == 16'd0) ? 16'd1 : wr_data_i[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    // Every bit reloads from div_q, so a mid-frame divisor write applies at the next boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_START;
                    cnt_d   = div_q - 16'd1;
                    shreg_d = mem_q[rptr_q];
                    par_d   = ^mem_q[rptr_q];
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_DATA;
                    cnt_d   = div_q - 16'd1;
                    bit_d   = 3'd0;
                end else cnt_d = cnt_q - 16'd1;
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = div_q - 16'd1;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PAR_EN ? S_PARITY : S_STOP;
                end else cnt_d = cnt_q - 16'd1;
            end
            S_PARITY: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_STOP;
                    cnt_d   = div_q - 16'd1;
                end else cnt_d = cnt_q - 16'd1;
            end
            S_STOP: begin
                if (cnt_q == 16'd0) state_d = S_IDLE;
                else                cnt_d   = cnt_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            S_START:  tx_o = 1'b0;
            S_DATA:   tx_o = shreg_q[0];
            S_PARITY: tx_o = par_q;
            default:  tx_o = 1'b1;
        endcase
    end

    always_comb begin
        rd_data_o = 32'd0;
        if (sel_i) begin
            case (reg_sel)
                2'd1: rd_data_o = {20'd0, 4'(count_q), 3'd0, PAR_EN, ovf_q,
                                   (state_q != S_IDLE), empty, full};
                2'd2: rd_data_o = {16'd0, div_q};
                default: rd_data_o = {31'd0, unused_ok & 1'b0};
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx: register map, frame timing, FIFO overflow,
// reset abort and mid-frame divisor change. Define UART_TX_PARITY_EN for the parity build.
module tb_mmio_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PARB = 32'h10;
    localparam int          FLEN = 11;
    localparam logic [15:0] F55  = 16'h04AA;
    localparam logic [15:0] F01  = 16'h0602;
    localparam logic [15:0] F07  = 16'h060E;
`else
    localparam logic [31:0] PARB = 32'h00;
    localparam int          FLEN = 10;
    localparam logic [15:0] F55  = 16'h02AA;
    localparam logic [15:0] F01  = 16'h0202;
    localparam logic [15:0] F07  = 16'h020E;
`endif
    localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_DIV = 32'h8, A_RSV = 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        memwr_i = 1'b0;
    logic [31:0] wr_data_i = '0;
    logic [31:0] rd_data_o;
    logic        tx_o;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] rv;
    logic [15:0] fb;

    mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
        .clk(clk), .rst(rst), .sel_i(sel_i), .addr_i(addr_i), .memwr_i(memwr_i),
        .wr_data_i(wr_data_i), .rd_data_o(rd_data_o), .tx_o(tx_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        sel_i = 1'b1; memwr_i = 1'b1; addr_i = a; wr_data_i = d;
        @(posedge clk); #1;
        sel_i = 1'b0; memwr_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        sel_i = 1'b1; memwr_i = 1'b0; addr_i = a;
        #1 d = rd_data_o;
        sel_i = 1'b0;
    endtask

    task automatic check_bits(input string tag, input logic [15:0] bits, input int n, input int div);
        for (int i = 0; i < n; i++)
            for (int c = 0; c < div; c++) begin
                @(posedge clk); #1;
                chk(tag, {31'd0, tx_o}, {31'd0, bits[i]});
            end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state and register map
        rd(A_STAT, rv); chk("rst_status", rv, 32'h2 | PARB);
        chk("rst_tx", {31'd0, tx_o}, 32'd1);
        rd(A_DIV, rv);  chk("rst_div", rv, 32'h01B2);
        rd(A_DATA, rv); chk("data_rd0", rv, 32'd0);
        wr(A_RSV, 32'hFFFF_FFFF);
        rd(A_RSV, rv);  chk("rsv_rd0", rv, 32'd0);
        rd(A_STAT, rv); chk("rsv_nofx", rv, 32'h2 | PARB);
        addr_i = A_DIV; #1 chk("nosel_rd0", rd_data_o, 32'd0);

        // 2: single frame 0x55 at divisor 4
        wr(A_DIV, 32'd4);
        rd(A_DIV, rv); chk("div4", rv, 32'd4);
        wr(A_DATA, 32'h55);
        chk("t2_idle", {31'd0, tx_o}, 32'd1);
        check_bits("t2_bit", F55, FLEN, 4);
        @(posedge clk); #1;
        rd(A_STAT, rv); chk("t2_done", rv, 32'h2 | PARB);

        // 3: burst of 9 stores, then overflow and clear
        wr(A_DIV, 32'd2);
        sel_i = 1'b1; memwr_i = 1'b1; addr_i = A_DATA;
        for (int i = 0; i < 9; i++) begin
            wr_data_i = 32'h10 + i;
            @(posedge clk); #1;
        end
        sel_i = 1'b0; memwr_i = 1'b0;
        rd(A_STAT, rv); chk("t3_full", rv, 32'h805 | PARB);
        wr(A_DATA, 32'hEE);
        rd(A_STAT, rv); chk("t3_ovf", rv, 32'h80D | PARB);
        wr(A_STAT, 32'h8);
        rd(A_STAT, rv); chk("t3_ovfclr", rv, 32'h805 | PARB);
        for (int i = 0; i < 2000; i++) begin
            rd(A_STAT, rv);
            if (rv == (32'h2 | PARB)) break;
            @(posedge clk); #1;
        end
        chk("t3_drain", rv, 32'h2 | PARB);

        // 4: reset during data bit 3 with a second byte queued
        wr(A_DIV, 32'd4);
        wr(A_DATA, 32'hA5);
        wr(A_DATA, 32'h3C);
        repeat (17) @(posedge clk);
        #1 chk("t4_bit3", {31'd0, tx_o}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t4_tx", {31'd0, tx_o}, 32'd1);
        rd(A_STAT, rv); chk("t4_status", rv, 32'h2 | PARB);
        rst = 1'b0;
        rd(A_DIV, rv);  chk("t4_div", rv, 32'h01B2);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            chk("t4_quiet", {31'd0, tx_o}, 32'd1);
        end

        // 5: divisor 8 rewritten to 2 during bit 0
        wr(A_DIV, 32'd8);
        wr(A_DATA, 32'h01);
        chk("t5_idle", {31'd0, tx_o}, 32'd1);
        check_bits("t5_start", F01, 1, 8);
        @(posedge clk); #1;
        chk("t5_b0", {31'd0, tx_o}, 32'd1);
        wr(A_DIV, 32'd2);
        chk("t5_b0", {31'd0, tx_o}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("t5_b0", {31'd0, tx_o}, 32'd1);
        end
        fb = F01 >> 2;
        check_bits("t5_rest", fb, FLEN - 2, 2);
        @(posedge clk); #1;
        rd(A_STAT, rv); chk("t5_done", rv, 32'h2 | PARB);

        // 6: divisor write of 0 stores 1; frame 0x07 at one clock per bit
        wr(A_DIV, 32'd0);
        rd(A_DIV, rv); chk("div0to1", rv, 32'd1);
        wr(A_DATA, 32'h07);
        chk("t6_idle", {31'd0, tx_o}, 32'd1);
        check_bits("t6_bit", F07, FLEN, 1);
        @(posedge clk); #1;
        chk("t6_tx_end", {31'd0, tx_o}, 32'd1);
        rd(A_STAT, rv); chk("t6_status", rv, 32'h2 | PARB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
